// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC sequencing controller: FSM states and the
// two-bit select code whose bits drive PcSel (bit 1) and dojump (bit 0).
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MEM   = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  // Branch wins over jump; the result is never 2'b11, so the PC unit can
  // never be handed both selects at once.
  function automatic logic [1:0] redirect_sel(input logic br, input logic j);
    if (br)     return SEL_BRANCH;
    else if (j) return SEL_JUMP;
    else        return SEL_NORMAL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at
// all-ones instead of wrapping so debug readouts never alias to small values.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count enabled events, stick at the top value.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (en && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// PC sequencing controller. Arbitrates memory wait, branch, jump and
// load-use requests (in that priority) and drives registered PC-unit
// selects, stall, flush, bubble and freeze controls. Redirects seen while
// memory is busy are parked in pend_br/pend_j and issued on release.
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             PcReSet,
  input  logic             branch_taken,
  input  logic             jump_req,
  input  logic             load_use,
  input  logic             mem_busy,
  output logic             PcSel,
  output logic             dojump,
  output logic             do_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             wait_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]      FLUSH_REM = 2'(FLUSH_CYCLES - 1);

  state_t            state, state_n;
  logic [1:0]        sel;
  logic              pend_br, pend_j;
  logic              pend_br_n, pend_j_n;
  logic [WAIT_W-1:0] wait_cnt, wait_base, wait_next;
  logic [1:0]        flush_cnt;

  logic              go_mem, go_redir, go_lu, hold_flush;
  logic [1:0]        sel_n;

  // Wait counter continues only while already in MEM_WAIT; a fresh entry
  // counts from zero. It saturates so the timeout compare stays valid.
  always_comb begin
    wait_base = (state == ST_MEM) ? wait_cnt : '0;
    wait_next = (wait_base == WAIT_MAX) ? wait_base : wait_base + 1'b1;
  end

  // Decide this edge's transition from current state and sampled requests.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    state_n    = ST_RUN;
    go_mem     = 1'b0;
    go_redir   = 1'b0;
    go_lu      = 1'b0;
    hold_flush = 1'b0;
    sel_n      = SEL_NORMAL;
    pend_br_n  = 1'b0;
    pend_j_n   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_busy) begin
          go_mem    = 1'b1;
          pend_br_n = branch_taken;
          pend_j_n  = jump_req & ~branch_taken;
        end else if (branch_taken || jump_req) begin
          go_redir = 1'b1;
          sel_n    = redirect_sel(branch_taken, jump_req);
        end else if (load_use) begin
          go_lu = 1'b1;
        end
      end
      ST_LU: begin
        // The stall lasts one cycle; only a memory wait or a resolved
        // branch changes where it goes next.
        if (mem_busy) begin
          go_mem    = 1'b1;
          pend_br_n = branch_taken;
          pend_j_n  = jump_req & ~branch_taken;
        end else if (branch_taken) begin
          go_redir = 1'b1;
          sel_n    = SEL_BRANCH;
        end
      end
      ST_MEM: begin
        if (mem_busy) begin
          go_mem    = 1'b1;
          pend_br_n = pend_br | branch_taken;
          pend_j_n  = (pend_j | jump_req) & ~(pend_br | branch_taken);
        end else if (pend_br || pend_j || branch_taken || jump_req) begin
          go_redir = 1'b1;
          sel_n    = redirect_sel(pend_br | branch_taken, pend_j | jump_req);
        end
      end
      ST_REDIR: begin
        // Flushed-slot requests are ignored; the flush remainder is dropped
        // if memory goes busy.
        if (mem_busy)               go_mem     = 1'b1;
        else if (flush_cnt != 2'd0) hold_flush = 1'b1;
      end
      default: ;
    endcase

    if (go_mem)                   state_n = ST_MEM;
    else if (go_redir || hold_flush) state_n = ST_REDIR;
    else if (go_lu)               state_n = ST_LU;
  end

  // Registered FSM state, pending flags and all control outputs.
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      state        <= ST_RUN;
      sel          <= SEL_NORMAL;
      do_stall     <= 1'b0;
      if_id_flush  <= 1'b0;
      id_ex_bubble <= 1'b0;
      pipe_freeze  <= 1'b0;
      wait_err     <= 1'b0;
      pend_br      <= 1'b0;
      pend_j       <= 1'b0;
      wait_cnt     <= '0;
      flush_cnt    <= 2'd0;
    end else begin
      state        <= state_n;
      sel          <= go_redir ? sel_n : SEL_NORMAL;
      do_stall     <= go_mem | go_lu;
      pipe_freeze  <= go_mem;
      id_ex_bubble <= go_lu | go_redir;
      if_id_flush  <= go_redir | hold_flush;
      pend_br      <= pend_br_n;
      pend_j       <= pend_j_n;
      wait_cnt     <= go_mem ? wait_next : '0;
      if (go_redir)        flush_cnt <= FLUSH_REM;
      else if (hold_flush) flush_cnt <= flush_cnt - 1'b1;
      else                 flush_cnt <= 2'd0;
      if (go_mem && (wait_next >= WAIT_MAX)) wait_err <= 1'b1;
    end
  end

  assign PcSel  = sel[1];
  assign dojump = sel[0];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (Clk),
    .rst (PcReSet),
    .en  (do_stall),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk (Clk),
    .rst (PcReSet),
    .en  (PcSel | dojump),
    .clr (1'b0),
    .q   (redir_cnt)
  );

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=15,
// CNT_W=4). Each cycle's expected controls are pushed to a scoreboard as
// the requests are driven and popped when the outputs appear.
module tb_pc_flow_ctrl;

  localparam int CW = 4;

  // ctrl vector: {PcSel, dojump, do_stall, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b001010;
  localparam logic [5:0] O_BR   = 6'b100110;
  localparam logic [5:0] O_J    = 6'b010110;
  localparam logic [5:0] O_FL   = 6'b000100;
  localparam logic [5:0] O_MEM  = 6'b001001;

  // request vector: {branch_taken, jump_req, load_use, mem_busy}
  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_MB   = 4'b0001;
  localparam logic [3:0] R_LU   = 4'b0010;
  localparam logic [3:0] R_J    = 4'b0100;
  localparam logic [3:0] R_BR   = 4'b1000;

  typedef struct packed {
    logic [5:0]    ctrl;
    logic          werr;
    logic [CW-1:0] sc;
    logic [CW-1:0] rc;
  } exp_t;

  logic          Clk = 1'b0;
  logic          PcReSet = 1'b0;
  logic          branch_taken = 1'b0, jump_req = 1'b0, load_use = 1'b0, mem_busy = 1'b0;
  logic          PcSel, dojump, do_stall, if_id_flush, id_ex_bubble, pipe_freeze, wait_err;
  logic [CW-1:0] stall_cnt, redir_cnt;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  logic [CW-1:0] m_stall = '0, m_redir = '0;
  logic          prev_stall = 1'b0, prev_redir = 1'b0, m_werr = 1'b0;

  pc_flow_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .Clk          (Clk),
    .PcReSet      (PcReSet),
    .branch_taken (branch_taken),
    .jump_req     (jump_req),
    .load_use     (load_use),
    .mem_busy     (mem_busy),
    .PcSel        (PcSel),
    .dojump       (dojump),
    .do_stall     (do_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_freeze  (pipe_freeze),
    .wait_err     (wait_err),
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
    return (inc && c != '1) ? c + 1'b1 : c;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.ctrl = {PcSel, dojump, do_stall, if_id_flush, id_ex_bubble, pipe_freeze};
    o.werr = wait_err;
    o.sc   = stall_cnt;
    o.rc   = redir_cnt;
    return o;
  endfunction

  // Select/stall exclusivity must hold in every cycle outside reset.
  always @(negedge Clk) begin
    if (!PcReSet) begin
      n_checks++;
      if ((PcSel & dojump) || (do_stall && (PcSel || dojump))) begin
        n_fail++;
        $display("FAIL invariant @%0t: PcSel=%b dojump=%b do_stall=%b, required no overlap",
                 $time, PcSel, dojump, do_stall);
      end
    end
  end

  // Drive one cycle of requests, push the expected post-edge outputs, then
  // pop and compare once the edge has passed.
  task automatic cyc(input string nm, input logic [3:0] req, input logic [5:0] ctrl);
    exp_t e, got;
    {branch_taken, jump_req, load_use, mem_busy} = req;
    m_stall = sat_inc(m_stall, prev_stall);
    m_redir = sat_inc(m_redir, prev_redir);
    e.ctrl = ctrl;
    e.werr = m_werr;
    e.sc   = m_stall;
    e.rc   = m_redir;
    sb.push_back(e);
    prev_stall = ctrl[3];
    prev_redir = ctrl[5] | ctrl[4];
    @(posedge Clk);
    #1;
    e   = sb.pop_front();
    got = observed();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got ctrl=%b werr=%b stall=%0d redir=%0d, expected ctrl=%b werr=%b stall=%0d redir=%0d",
               nm, $time, got.ctrl, got.werr, got.sc, got.rc, e.ctrl, e.werr, e.sc, e.rc);
    end
  endtask

  // Assert reset asynchronously, confirm outputs clear immediately, then
  // release aligned one time unit after a rising edge.
  task automatic apply_reset(input string nm);
    exp_t got;
    {branch_taken, jump_req, load_use, mem_busy} = R_NONE;
    PcReSet = 1'b1;
    #1;
    got = observed();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: got ctrl=%b werr=%b stall=%0d redir=%0d, expected all zero",
               nm, got.ctrl, got.werr, got.sc, got.rc);
    end
    repeat (2) @(posedge Clk);
    #1;
    PcReSet    = 1'b0;
    m_stall    = '0;
    m_redir    = '0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    m_werr     = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    apply_reset("reset_async");
    for (int i = 0; i < 5; i++) cyc("reset_idle", R_NONE, O_IDLE);
  endtask

  task automatic test_load_use();
    cyc("lu_stall", R_LU, O_LU);
    cyc("lu_release", R_NONE, O_IDLE);
    cyc("lu_after", R_NONE, O_IDLE);
  endtask

  task automatic test_branch_jump();
    cyc("bj_branch_wins", R_BR | R_J, O_BR);
    cyc("bj_flush2", R_NONE, O_FL);
    cyc("bj_done", R_NONE, O_IDLE);
    cyc("j_only", R_J, O_J);
    cyc("j_flush2", R_NONE, O_FL);
    cyc("j_done", R_NONE, O_IDLE);
  endtask

  task automatic test_flush_window();
    cyc("fw_branch", R_BR, O_BR);
    cyc("fw_ignore_req", R_J | R_LU, O_FL);
    cyc("fw_done", R_NONE, O_IDLE);
    cyc("fw_jump", R_J, O_J);
    cyc("fw_mem_drops_flush", R_MB | R_BR, O_MEM);
    cyc("fw_mem_release", R_NONE, O_IDLE);
  endtask

  task automatic test_mem_jump();
    cyc("mj_busy1", R_MB | R_J, O_MEM);
    for (int i = 0; i < 3; i++) cyc("mj_busy", R_MB, O_MEM);
    cyc("mj_release_jump", R_NONE, O_J);
    cyc("mj_flush2", R_NONE, O_FL);
    cyc("mj_done", R_NONE, O_IDLE);
  endtask

  task automatic test_lu_override();
    cyc("lo_stall", R_LU, O_LU);
    cyc("lo_branch", R_BR | R_LU, O_BR);
    cyc("lo_flush2", R_NONE, O_FL);
    cyc("lo_done", R_NONE, O_IDLE);
  endtask

  task automatic test_priority();
    cyc("pr_mem_first", R_MB | R_BR | R_J | R_LU, O_MEM);
    cyc("pr_pend_branch", R_NONE, O_BR);
    cyc("pr_flush2", R_NONE, O_FL);
    cyc("pr_done", R_NONE, O_IDLE);
    cyc("pr_jump_over_lu", R_J | R_LU, O_J);
    cyc("pr_flush2b", R_NONE, O_FL);
    cyc("pr_doneb", R_NONE, O_IDLE);
  endtask

  task automatic test_mem_timeout();
    for (int k = 1; k <= 20; k++) begin
      if (k >= 15) m_werr = 1'b1;
      cyc("to_busy", R_MB, O_MEM);
    end
    for (int i = 0; i < 3; i++) cyc("to_sticky", R_NONE, O_IDLE);
  endtask

  task automatic test_reset_mid_redirect();
    cyc("rm_branch", R_BR, O_BR);
    apply_reset("rm_reset_async");
    cyc("rm_no_flush", R_NONE, O_IDLE);
    cyc("rm_idle", R_NONE, O_IDLE);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      cyc("sat_lu", R_LU, O_LU);
      cyc("sat_idle", R_NONE, O_IDLE);
    end
    for (int i = 0; i < 17; i++) begin
      cyc("sat_br", R_BR, O_BR);
      cyc("sat_fl", R_NONE, O_FL);
      cyc("sat_done", R_NONE, O_IDLE);
    end
    cyc("sat_final", R_NONE, O_IDLE);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_flush_window();
    test_mem_jump();
    test_lu_override();
    test_priority();
    test_mem_timeout();
    test_reset_mid_redirect();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
Sequencing controller for the PC unit. It arbitrates branch, jump, load-use and memory-wait requests, and drives the PC unit's PcSel / dojump / do_stall controls plus the pipeline flush and bubble signals. It guarantees the PC unit never sees the invalid select 2'b11. It holds redirects that arrive during a memory stall until the stall releases, and it counts stall and redirect events for debug.

Parameters:
FLUSH_CYCLES, 1, number of cycles if_id_flush is held after a redirect (1..3)
MEM_TIMEOUT, 15, maximum consecutive mem_busy cycles before wait_err is set
CNT_W, 16, width of the event counters

Ports:
Clk  in  1  system clock, rising edge
PcReSet  in  1  asynchronous, active-high reset
branch_taken  in  1  resolved taken branch in EX this cycle
jump_req  in  1  jump decoded in ID this cycle
load_use  in  1  load-use hazard detected in ID this cycle
mem_busy  in  1  data memory not ready; whole pipeline must freeze
PcSel  out  1  branch select to PC unit
dojump  out  1  jump select to PC unit
do_stall  out  1  hold PC (effective only when PcSel=dojump=0)
if_id_flush  out  1  clear IF/ID register
id_ex_bubble  out  1  insert NOP into ID/EX
pipe_freeze  out  1  freeze all pipeline registers
wait_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  total stall cycles (load-use + mem)
redir_cnt  out  CNT_W  total redirects issued

Behaviour:
- All outputs, counters, state and pending flags are registered. Requests sampled at rising edge t drive outputs during cycle t+1; the PC unit acts at edge t+1.
- Reset: state=RUN. All outputs 0, counters 0, pending flags 0, flush counter 0. Assertion mid-operation aborts any pending redirect immediately.
- States: RUN, LU_STALL, MEM_WAIT, REDIRECT.
- Priority at each sample: mem_busy > branch_taken > jump_req > load_use > normal.
- RUN:
  - mem_busy: go to MEM_WAIT. Latch branch_taken/jump_req into pend_br/pend_j (branch wins, pend_j cleared).
  - branch_taken: go to REDIRECT with PcSel=1, dojump=0.
  - jump_req (no branch): go to REDIRECT with dojump=1, PcSel=0.
  - load_use: go to LU_STALL.
  - otherwise: stay in RUN with all controls 0.
- LU_STALL: do_stall=1 and id_ex_bubble=1 for exactly one cycle, then return to RUN. A branch_taken sampled in LU_STALL overrides: go to REDIRECT, and the stall is not re-issued.
- MEM_WAIT:
  - Outputs: pipe_freeze=1, do_stall=1, PcSel=dojump=0.
  - Wait counter increments each busy cycle. When it reaches MEM_TIMEOUT, set wait_err (sticky until reset) and keep waiting.
  - When mem_busy drops: if pend_br or pend_j, go to REDIRECT with the matching select; else go to RUN. Clear pend flags and wait counter.
- REDIRECT:
  - Select pulse (PcSel or dojump) lasts exactly 1 cycle.
  - if_id_flush=1 for FLUSH_CYCLES cycles starting that same cycle; id_ex_bubble=1 in the first cycle only.
  - New requests during the flush window are ignored except mem_busy, which goes to MEM_WAIT with the flush remainder dropped.
  - Return to RUN when the flush counter expires.
- Invariant: PcSel & dojump is never 1. do_stall is 0 in any cycle where PcSel or dojump is 1.
- Counters:
  - stall_cnt increments on every cycle with do_stall=1.
  - redir_cnt increments on every cycle with PcSel|dojump.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package pc_ctrl_pkg:
  - State encoding constants ST_RUN=2'd0, ST_LU=2'd1, ST_MEM=2'd2, ST_REDIR=2'd3.
  - Select codes SEL_NORMAL=2'b00, SEL_JUMP=2'b01, SEL_BRANCH=2'b10.
- Sub-module: sat_counter (parameterised width, enable, synchronous-clear, saturating), instantiated twice for stall_cnt and redir_cnt.

Test Plan:
- Reset then idle 5 cycles → all outputs 0, state RUN; pulse PcReSet mid-REDIRECT → outputs 0 on the same edge, counters 0.
- load_use=1 for one cycle → next cycle do_stall=1 and id_ex_bubble=1, following cycle all 0; stall_cnt=1.
- branch_taken and jump_req both 1 → PcSel=1, dojump=0 for 1 cycle; if_id_flush high for FLUSH_CYCLES; redir_cnt=1.
- mem_busy high for 4 cycles with jump_req pulsed in the first → pipe_freeze=1 for 4 cycles, then dojump=1 for 1 cycle; stall_cnt=4, redir_cnt=1.
- mem_busy held 20 cycles with MEM_TIMEOUT=15 → wait_err rises after the 15th busy cycle and stays 1 after mem_busy drops.
- Force stall_cnt near all-ones (CNT_W=4) and stall 20 cycles → counter holds at 4'hF; check every cycle that PcSel & dojump is never 1.
